// File: rtl/alu_pkg.sv
// Shared opcode constants and FSM encoding for the multi-cycle ALU.
package alu_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_LSL   = 4'b0011;
  localparam logic [3:0] OP_LSR   = 4'b0100;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_PASSB = 4'b0111;
  localparam logic [3:0] OP_MUL   = 4'b1000;

  typedef enum logic {
    IDLE,
    MUL
  } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per clock, WIDTH steps.
module alu_mul_iter #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_d;
  logic [CW-1:0]    cnt;

  assign acc_d   = acc + (b_q[0] ? a_q : '0);
  assign busy    = (cnt != '0);
  // done flags the final step so the product can be taken on that same edge
  assign done    = (cnt == CW'(1));
  assign product = acc_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      acc <= '0;
      cnt <= '0;
    end else if (start) begin
      a_q <= a;
      b_q <= b;
      acc <= '0;
      cnt <= CW'(WIDTH);
    end else if (busy) begin
      acc <= acc_d;
      a_q <= a_q << 1;
      b_q <= b_q >> 1;
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes, NZCV flags and a one-slot
// registered output.
module alu_mc
  import alu_pkg::*;
#(
  parameter  int WIDTH = 64,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [WIDTH-1:0] BusA,
  input  logic [WIDTH-1:0] BusB,
  input  logic [3:0]       ALUCtrl,
  input  logic             InValid,
  output logic             InReady,
  output logic [WIDTH-1:0] BusW,
  output logic             Zero,
  output logic             Negative,
  output logic             Carry,
  output logic             Overflow,
  output logic             Illegal,
  output logic             OutValid,
  input  logic             OutReady
);

  state_t state;
  state_t state_d;

  logic             accept;
  logic             is_mul;
  logic             mul_busy;
  logic             mul_done;
  logic [WIDTH-1:0] mul_prod;

  logic [WIDTH-1:0] res;
  logic             res_c;
  logic             res_v;
  logic             res_ill;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   dif;
  logic [SHW-1:0]   shamt;

  // OutReady feeds InReady combinationally so a full slot can turn over
  // every cycle
  assign InReady = (state == IDLE) & ~mul_busy & (~OutValid | OutReady);
  assign accept  = InValid & InReady;
  assign is_mul  = (ALUCtrl == OP_MUL);

  assign Zero     = (BusW == '0);
  assign Negative = BusW[WIDTH-1];

  assign sum   = {1'b0, BusA} + {1'b0, BusB};
  assign dif   = {1'b0, BusA} + {1'b0, ~BusB} + {{WIDTH{1'b0}}, 1'b1};
  assign shamt = BusB[SHW-1:0];

  always_comb begin
    res     = '0;
    res_c   = 1'b0;
    res_v   = 1'b0;
    res_ill = 1'b0;
    unique case (ALUCtrl)
      OP_AND:   res = BusA & BusB;
      OP_OR:    res = BusA | BusB;
      OP_ADD: begin
        res   = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
        res_v = (BusA[WIDTH-1] == BusB[WIDTH-1]) &
                (sum[WIDTH-1] != BusA[WIDTH-1]);
      end
      OP_SUB: begin
        res   = dif[WIDTH-1:0];
        res_c = dif[WIDTH];
        res_v = (BusA[WIDTH-1] != BusB[WIDTH-1]) &
                (dif[WIDTH-1] != BusA[WIDTH-1]);
      end
      OP_LSL:   res = BusA << shamt;
      OP_LSR:   res = BusA >> shamt;
      OP_PASSB: res = BusB;
      OP_MUL:   res = '0;
      default:  res_ill = 1'b1;
    endcase
  end

  alu_mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk    (CLK),
    .rst    (Reset),
    .start  (accept & is_mul),
    .a      (BusA),
    .b      (BusB),
    .busy   (mul_busy),
    .done   (mul_done),
    .product(mul_prod)
  );

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (accept && is_mul) state_d = MUL;
      MUL:  if (mul_done)         state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      BusW     <= '0;
      Carry    <= 1'b0;
      Overflow <= 1'b0;
      Illegal  <= 1'b0;
      OutValid <= 1'b0;
    end else if (accept && !is_mul) begin
      BusW     <= res;
      Carry    <= res_c;
      Overflow <= res_v;
      Illegal  <= res_ill;
      OutValid <= 1'b1;
    end else if (mul_done) begin
      BusW     <= mul_prod;
      Carry    <= 1'b0;
      Overflow <= 1'b0;
      Illegal  <= 1'b0;
      OutValid <= 1'b1;
    end else if (OutReady) begin
      OutValid <= 1'b0;
    end
  end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised, multi-cycle successor to the 64-bit combinational ALU.
- Keeps the existing ALUCtrl encodings and adds shifts, an iterative multiply and full NZCV flags.
- Operands enter and results leave through valid/ready handshakes, so the block can sit between pipeline stages of the datapath.
- Results are held in a single-slot output register.

Parameters:
WIDTH, 64, operand/result width in bits (power of 2, at least 8).
SHW, $clog2(WIDTH), shift-amount bits taken from BusB; derived, never overridden.

Ports:
CLK  input  1  clock, all state updates on the rising edge.
Reset  input  1  asynchronous, active-high reset.
BusA  input  WIDTH  operand A.
BusB  input  WIDTH  operand B; low SHW bits are the shift amount.
ALUCtrl  input  4  operation select.
InValid  input  1  BusA/BusB/ALUCtrl valid.
InReady  output  1  block can accept an operation this cycle.
BusW  output  WIDTH  registered result.
Zero  output  1  BusW == 0.
Negative  output  1  BusW[WIDTH-1].
Carry  output  1  carry flag.
Overflow  output  1  signed overflow flag.
Illegal  output  1  accepted ALUCtrl was unsupported.
OutValid  output  1  BusW and flags valid.
OutReady  input  1  consumer takes the result.

Behaviour:
- Opcodes:
  - 0000 AND; 0001 OR; 0010 ADD; 0110 SUB (A-B); 0111 PassB.
  - 0011 LSL A by BusB[SHW-1:0]; 0100 LSR (logical) A by BusB[SHW-1:0].
  - 1000 MUL: low WIDTH bits of unsigned A*B.
  - Any other code: BusW=0, Illegal=1, flags C=V=0.
- Flags:
  - Zero and Negative are computed from the registered BusW.
  - ADD: Carry = carry out of bit WIDTH-1; Overflow = signed overflow.
  - SUB: Carry = NOT borrow (1 when A >= B unsigned); Overflow = signed overflow.
  - All other ops: Carry=0, Overflow=0.
- Acceptance: a transfer happens on a rising edge with InValid & InReady.
  - InReady = (state==IDLE) & (!OutValid | OutReady). The combinational path from OutReady to InReady is intentional.
- States:
  - IDLE: a non-MUL accept loads BusW/flags on that edge; OutValid=1 from the next cycle (latency 1). Back-to-back accepts at one per cycle are allowed when OutReady=1.
  - MUL: entered on a MUL accept. Operands are latched, product accumulator cleared, counter set to WIDTH. Each edge performs one shift-add step and decrements the counter. After exactly WIDTH edges in MUL, BusW loads the product, OutValid=1 and the state returns to IDLE. Accept-to-OutValid latency is WIDTH+1 cycles. InReady=0 throughout MUL.
- Output slot: while OutValid=1 & OutReady=0, BusW, flags and Illegal are held stable. OutValid falls on the edge where OutReady=1, unless a new accept reloads it on that same edge.
- Inputs are ignored whenever InReady=0; changes on BusA/BusB during MUL have no effect.
- Reset (async, any time, including mid-MUL):
  - state=IDLE; BusW=0, Zero=1, Negative=0, Carry=0, Overflow=0, Illegal=0, OutValid=0.
  - Counter and accumulator are cleared; an in-flight MUL is discarded.
  - InReady is 1 in the first cycle after Reset deasserts.
- Width rules:
  - Shift amounts use only the low SHW bits, so shifting by WIDTH or more wraps modulo WIDTH.
  - Multiply overflow beyond WIDTH bits is discarded silently.

Decomposition:
- Package alu_pkg holds:
  - 4-bit opcode constants: OP_AND, OP_OR, OP_ADD, OP_LSL, OP_LSR, OP_SUB, OP_PASSB, OP_MUL.
  - State encoding: IDLE, MUL.
- One sub-module: alu_mul_iter, the WIDTH-step shift-add multiplier.
  - Inputs: start, a, b.
  - Outputs: busy, done, product.
  - alu_mc owns the handshake and flag logic.

Test Plan:
- Reset, then ADD 0x69+0x420 with OutReady=1 -> OutValid one cycle after accept, BusW=0x489, Zero=0, Carry=0.
- SUB 0xFFFF-0xFFFF -> BusW=0, Zero=1, Carry=1. SUB 0x0-0x1 -> BusW=all ones, Negative=1, Carry=0.
- WIDTH=8 ADD 0x7F+0x01 -> BusW=0x80, Overflow=1, Negative=1. ADD 0xFF+0x01 -> BusW=0, Carry=1, Zero=1.
- MUL 0x1234*0x10 (WIDTH=64) -> InReady=0 for 64 cycles, OutValid exactly 65 cycles after accept, BusW=0x12340. LSL 0x1 by 65 -> BusW=0x2 (modulo wrap).
- Hold OutReady=0 with 3 queued ADDs -> first result held stable, InReady=0. Release OutReady -> results 1,2,3 delivered in order, none dropped or duplicated.
- Assert Reset 10 cycles into a MUL -> OutValid=0 and BusW=0 immediately. After release, AND 0x7382&0x1F1F -> BusW=0x1302. ALUCtrl=0xF -> Illegal=1, BusW=0.
